multicycle_mem_responder: RTL and testbench

// - Unified instruction/data memory that services the multicycle controller's memread/memwrite strobes.
// - Sits on the datapath memory port: adr comes from the IorD mux, write_data from register B, read_data feeds IR/MDR.
// - Models configurable wait states and signals completion with a one-cycle mem_ready pulse.

---
 rtl/multicycle_mem_responder.sv | 133 +++++++++++++
 tb/tb_multicycle_mem_responder.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/multicycle_mem_responder.sv
// multicycle_mem_responder
// Unified instruction/data memory for the multicycle datapath. A held
// memread/memwrite strobe is accepted in IDLE. The access then spends
// WAIT_CYCLES+1 cycles in WAIT and one cycle in DONE, where mem_ready pulses.
// Build option: define MISALIGN_CHECK_EN to flag and suppress accesses whose
// byte address is not word aligned. Without it, adr[1:0] is ignored and
// misalign_err stays 0.
module multicycle_mem_responder #(
  parameter int    DEPTH_WORDS = 1024,
  parameter int    WAIT_CYCLES = 2,
  parameter string INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memread,
  input  logic        memwrite,
  input  logic [31:0] adr,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        mem_ready,
  output logic        mem_busy,
  output logic        misalign_err
);

  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [3:0]    counter;
  logic [3:0]    counter_next;
  logic          accept;
  logic [AW-1:0] idx_q;
  logic [31:0]   data_q;
  logic          write_q;
  logic          misalign_q;
  logic          unused_adr_bits;

  logic [31:0] mem [DEPTH_WORDS];

  // Address bits above the index wrap away, and the byte offset is only used by the misalign check.
  assign unused_adr_bits = ^{adr[31:AW+2], adr[1:0]};

  assign accept    = (state == S_IDLE) && (memread || memwrite);
  assign mem_ready = (state == S_DONE);
  assign mem_busy  = (state != S_IDLE);

  // Next-state logic: accept in IDLE, count down wait states, DONE lasts one cycle.
  always_comb begin
    state_next   = state;
    counter_next = counter;
    case (state)
      S_IDLE: begin
        if (memread || memwrite) begin
          state_next   = S_WAIT;
          counter_next = 4'(WAIT_CYCLES);
        end
      end
      S_WAIT: begin
        if (counter == 4'd0) begin
          state_next = S_DONE;
        end else begin
          counter_next = counter - 4'd1;
        end
      end
      S_DONE: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next   = S_IDLE;
        counter_next = 4'd0;
      end
    endcase
  end

  // State and wait-counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      counter <= 4'd0;
    end else begin
      state   <= state_next;
      counter <= counter_next;
    end
  end

  // Capture the request at accept so later changes on adr/write_data are ignored; on a read+write the write wins.
  always_ff @(posedge clk) begin
    if (accept) begin
      idx_q   <= adr[AW+1:2];
      data_q  <= write_data;
      write_q <= memwrite;
    end
  end

`ifdef MISALIGN_CHECK_EN
  // Remember whether the accepted address had a nonzero byte offset.
  always_ff @(posedge clk) begin
    if (reset) begin
      misalign_q <= 1'b0;
    end else if (accept) begin
      misalign_q <= (adr[1:0] != 2'b00);
    end
  end

  assign misalign_err = (state == S_DONE) && misalign_q;
`else
  assign misalign_q   = 1'b0;
  assign misalign_err = 1'b0;
`endif

  // Load read_data on the edge entering DONE; writes and suppressed accesses leave it untouched.
  always_ff @(posedge clk) begin
    if (reset) begin
      read_data <= 32'd0;
    end else if ((state == S_WAIT) && (counter == 4'd0) && !write_q && !misalign_q) begin
      read_data <= mem[idx_q];
    end
  end

  // Commit a store on the edge leaving DONE; a reset arriving in DONE drops it.
  always_ff @(posedge clk) begin
    if (!reset && (state == S_DONE) && write_q && !misalign_q) begin
      mem[idx_q] <= data_q;
    end
  end

endmodule

// File: tb/tb_multicycle_mem_responder.sv
// tb_multicycle_mem_responder
// Directed bench for multicycle_mem_responder. A WAIT_CYCLES=2 instance runs a
// vector table plus reset corner cases. A WAIT_CYCLES=0 instance checks
// back-to-back latency. Expectations for misaligned accesses follow
// MISALIGN_CHECK_EN.
module tb_multicycle_mem_responder;

  localparam int W1 = 2;
  localparam int W2 = 0;
`ifdef MISALIGN_CHECK_EN
  localparam bit MIS_EN = 1'b1;
`else
  localparam bit MIS_EN = 1'b0;
`endif

  typedef struct {
    bit          rd;
    bit          wr;
    logic [31:0] adr;
    logic [31:0] data;
    logic [31:0] exp_rd;
    bit          exp_mis;
  } vec_t;

  logic        clk;
  logic        reset;
  logic        memread1, memwrite1, memread2, memwrite2;
  logic [31:0] adr1, wdata1, adr2, wdata2;
  logic [31:0] rdata1, rdata2;
  logic        ready1, busy1, mis1, ready2, busy2, mis2;

  int tests_run = 0;
  int tests_failed = 0;

  multicycle_mem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(W1)) dut1 (
    .clk(clk), .reset(reset), .memread(memread1), .memwrite(memwrite1),
    .adr(adr1), .write_data(wdata1), .read_data(rdata1),
    .mem_ready(ready1), .mem_busy(busy1), .misalign_err(mis1)
  );

  multicycle_mem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(W2)) dut2 (
    .clk(clk), .reset(reset), .memread(memread2), .memwrite(memwrite2),
    .adr(adr2), .write_data(wdata2), .read_data(rdata2),
    .mem_ready(ready2), .mem_busy(busy2), .misalign_err(mis2)
  );

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // One full transaction on dut1 (which=0) or dut2 (which=1). Inputs are scrambled after accept.
  task automatic applyStimulus(input int which, input bit rd, input bit wr,
                               input logic [31:0] a, input logic [31:0] d,
                               output int lat, output logic [31:0] rdat, output logic mis,
                               output logic busy_at_ready, output logic ready_after,
                               output logic busy_after);
    bit got;
    @(negedge clk);
    if (which == 0) begin
      memread1 = rd; memwrite1 = wr; adr1 = a; wdata1 = d;
    end else begin
      memread2 = rd; memwrite2 = wr; adr2 = a; wdata2 = d;
    end
    @(posedge clk);
    @(negedge clk);
    if (which == 0) begin
      adr1 = ~a; wdata1 = ~d;
    end else begin
      adr2 = ~a; wdata2 = ~d;
    end
    lat = 0;
    got = 1'b0;
    while (!got && lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      got = (which == 0) ? ready1 : ready2;
    end
    rdat          = (which == 0) ? rdata1 : rdata2;
    mis           = (which == 0) ? mis1 : mis2;
    busy_at_ready = (which == 0) ? busy1 : busy2;
    if (which == 0) begin
      memread1 = 1'b0; memwrite1 = 1'b0;
    end else begin
      memread2 = 1'b0; memwrite2 = 1'b0;
    end
    @(negedge clk);
    ready_after = (which == 0) ? ready1 : ready2;
    busy_after  = (which == 0) ? busy1 : busy2;
  endtask

  vec_t        vecs [12];
  int          lat;
  logic [31:0] rdat;
  logic        mis, bz, ra, ba;

  // Main sequence.
  initial begin
    vecs[0]  = '{rd:0, wr:1, adr:32'h0000_0040, data:32'hDEAD_BEEF, exp_rd:32'h0,         exp_mis:0};
    vecs[1]  = '{rd:1, wr:0, adr:32'h0000_0040, data:32'h0,         exp_rd:32'hDEAD_BEEF, exp_mis:0};
    vecs[2]  = '{rd:0, wr:1, adr:32'h0000_1000, data:32'h1234_5678, exp_rd:32'hDEAD_BEEF, exp_mis:0};
    vecs[3]  = '{rd:1, wr:0, adr:32'h0000_0000, data:32'h0,         exp_rd:32'h1234_5678, exp_mis:0};
    vecs[4]  = '{rd:0, wr:1, adr:32'h0000_0080, data:32'h1111_2222, exp_rd:32'h1234_5678, exp_mis:0};
    vecs[5]  = '{rd:1, wr:0, adr:32'h0000_0080, data:32'h0,         exp_rd:32'h1111_2222, exp_mis:0};
    vecs[6]  = '{rd:1, wr:1, adr:32'h0000_0044, data:32'h55AA_55AA, exp_rd:32'h1111_2222, exp_mis:0};
    vecs[7]  = '{rd:1, wr:0, adr:32'h0000_0044, data:32'h0,         exp_rd:32'h55AA_55AA, exp_mis:0};
    vecs[8]  = '{rd:1, wr:0, adr:32'hFFFF_F040, data:32'h0,         exp_rd:32'hDEAD_BEEF, exp_mis:0};
    vecs[9]  = '{rd:0, wr:1, adr:32'h0000_0042, data:32'h0000_0001, exp_rd:32'hDEAD_BEEF, exp_mis:MIS_EN};
    vecs[10] = '{rd:1, wr:0, adr:32'h0000_0040, data:32'h0,
                 exp_rd:(MIS_EN ? 32'hDEAD_BEEF : 32'h0000_0001), exp_mis:0};
    vecs[11] = '{rd:1, wr:0, adr:32'h0000_0045, data:32'h0,
                 exp_rd:(MIS_EN ? 32'hDEAD_BEEF : 32'h55AA_55AA), exp_mis:MIS_EN};

    memread1 = 0; memwrite1 = 0; adr1 = 0; wdata1 = 0;
    memread2 = 0; memwrite2 = 0; adr2 = 0; wdata2 = 0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    $display("[TB] reset and idle checks");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("idle_read_data", rdata1, 32'h0);
      checkOutput("idle_mem_ready", 32'(ready1), 32'h0);
      checkOutput("idle_mem_busy", 32'(busy1), 32'h0);
      checkOutput("idle_misalign", 32'(mis1), 32'h0);
    end

    $display("[TB] vector table on WAIT_CYCLES=%0d", W1);
    for (int i = 0; i < 12; i++) begin
      applyStimulus(0, vecs[i].rd, vecs[i].wr, vecs[i].adr, vecs[i].data, lat, rdat, mis, bz, ra, ba);
      checkOutput($sformatf("v%0d_latency", i), 32'(lat), 32'(W1 + 1));
      checkOutput($sformatf("v%0d_read_data", i), rdat, vecs[i].exp_rd);
      checkOutput($sformatf("v%0d_misalign", i), 32'(mis), 32'(vecs[i].exp_mis));
      checkOutput($sformatf("v%0d_busy_at_ready", i), 32'(bz), 32'h1);
      checkOutput($sformatf("v%0d_ready_pulse", i), 32'(ra), 32'h0);
      checkOutput($sformatf("v%0d_busy_after", i), 32'(ba), 32'h0);
    end

    $display("[TB] reset during WAIT aborts a write");
    @(negedge clk);
    memwrite1 = 1'b1; adr1 = 32'h0000_0080; wdata1 = 32'hAAAA_5555;
    @(posedge clk);
    @(negedge clk);
    memwrite1 = 1'b0;
    checkOutput("abort_busy_in_wait", 32'(busy1), 32'h1);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    checkOutput("abort_busy", 32'(busy1), 32'h0);
    checkOutput("abort_ready", 32'(ready1), 32'h0);
    checkOutput("abort_read_data", rdata1, 32'h0);
    repeat (4) @(negedge clk);
    applyStimulus(0, 1'b1, 1'b0, 32'h0000_0080, 32'h0, lat, rdat, mis, bz, ra, ba);
    checkOutput("abort_readback", rdat, 32'h1111_2222);
    checkOutput("abort_readback_latency", 32'(lat), 32'(W1 + 1));

    $display("[TB] back-to-back reads on WAIT_CYCLES=%0d", W2);
    applyStimulus(1, 1'b0, 1'b1, 32'h0000_0000, 32'hCAFE_F00D, lat, rdat, mis, bz, ra, ba);
    checkOutput("w0_write0_latency", 32'(lat), 32'(W2 + 1));
    applyStimulus(1, 1'b0, 1'b1, 32'h0000_0004, 32'h0BAD_C0DE, lat, rdat, mis, bz, ra, ba);
    checkOutput("w0_write1_latency", 32'(lat), 32'(W2 + 1));
    applyStimulus(1, 1'b1, 1'b0, 32'h0000_0000, 32'h0, lat, rdat, mis, bz, ra, ba);
    checkOutput("w0_read0_latency", 32'(lat), 32'(W2 + 1));
    checkOutput("w0_read0_data", rdat, 32'hCAFE_F00D);
    applyStimulus(1, 1'b1, 1'b0, 32'h0000_0004, 32'h0, lat, rdat, mis, bz, ra, ba);
    checkOutput("w0_read1_latency", 32'(lat), 32'(W2 + 1));
    checkOutput("w0_read1_data", rdat, 32'h0BAD_C0DE);
    checkOutput("w0_ready_pulse", 32'(ra), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
